adder_byte_sequencer: RTL and testbench
=======================================

ADDER_BYTE_SEQUENCER -- requirements
Module: adder_byte_sequencer

Interface
REQ-001 SHALL: clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL: rst, input, 1, synchronous active-high reset, sampled on rising clk edge.
REQ-003 SHALL: req0_valid/req1_valid, input, 1 each, requester has an operation pending.
REQ-004 SHALL: req0_ready/req1_ready, output, 1 each, operation accepted on any edge where valid && ready.
REQ-005 SHALL: req0_a/req1_a and req0_b/req1_b, input, 32 each, operands.
REQ-006 SHALL: req0_sub/req1_sub, input, 1 each: 0 = a+b, 1 = a-b.
REQ-007 SHALL: rsp_valid, output, 1, result available.
REQ-008 SHALL: rsp_ready, input, 1, consumer takes result on any edge where rsp_valid && rsp_ready.
REQ-009 SHALL: rsp_result, output, 32, sum/difference mod 2^32.
REQ-010 SHALL: rsp_cout, output, 1, carry out of bit 31 (for sub: 1 = no borrow).
REQ-011 SHALL: rsp_ovf, output, 1, two's-complement signed overflow.
REQ-012 SHALL: rsp_id, output, 1, index of the requester that issued the result.
REQ-013 SHALL: busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL: contain exactly one 8-bit ripple adder slice (a8+b8+cin -> sum8, cout); all 32-bit arithmetic is done by time-sharing it across 4 byte passes.
REQ-015 SHALL: FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-016 SHALL: in IDLE, reqN_ready = 1 only for the granted requester; both readys 0 in CALC and DONE.
REQ-017 SHALL: grant rule in IDLE: one valid -> grant it; both valid -> grant the requester named by the priority pointer prio; none valid -> no grant.
REQ-018 SHALL: on accept, capture a, b, sub, id into internal registers, set prio to the other requester, go IDLE->CALC with byte index 0.
REQ-019 SHALL: operand preparation: b' = sub ? ~b : b; initial carry = sub.
REQ-020 SHALL: CALC lasts exactly 4 cycles; in cycle k (k=0..3) compute byte k = a[8k+7:8k] + b'[8k+7:8k] + carry, store into result byte k, register slice cout as next carry.
REQ-021 SHALL: after byte 3, go CALC->DONE; rsp_cout = final carry; rsp_ovf = (a[31]==b'[31]) && (result[31]!=a[31]).
REQ-022 SHALL: latency: accept on edge E -> rsp_valid high in the cycle after edge E+4 (5 cycles after accept edge).
REQ-023 SHALL: in DONE, rsp_valid = 1 and rsp_result/rsp_cout/rsp_ovf/rsp_id held stable until the handshake edge; then DONE->IDLE.
REQ-024 SHALL: rsp_valid = 0 in IDLE and CALC; next accept possible no earlier than the IDLE cycle after the response handshake.
REQ-025 SHALL: requester inputs changing after the accept edge have no effect on the in-flight operation.
REQ-026 SHALL: reqN_valid deasserted before being granted is legal; no accept occurs.

Reset
REQ-027 SHALL: on rst: state IDLE, prio 0, carry 0, byte index 0, result registers 0, rsp_valid 0, rsp_result 0, rsp_cout 0, rsp_ovf 0, rsp_id 0, busy 0.
REQ-028 SHALL: rst in CALC or DONE abandons the operation; no response is ever issued for it.
REQ-029 SHALL: rst has priority over any simultaneous accept or response handshake.

Verification
REQ-030 SHALL: req0 add 0x000000FF+0x00000001, rsp_ready=1 -> rsp_valid 5 cycles after accept, result 0x00000100, cout 0, ovf 0, id 0.
REQ-031 SHALL: req1 sub 0x00000005-0x00000007 -> result 0xFFFFFFFE, cout 0, ovf 0, id 1; sub 7-5 -> 0x00000002, cout 1.
REQ-032 SHALL: 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf 1, cout 0; 0xFFFFFFFF+0x00000001 -> 0x00000000, cout 1, ovf 0.
REQ-033 SHALL: both requesters valid continuously after reset -> grant order 0,1,0,1; rsp_id sequence matches.
REQ-034 SHALL: rsp_ready held 0 for 3 cycles in DONE -> rsp_* stable, both readys 0, busy 1; handshake on 4th cycle -> IDLE.
REQ-035 SHALL: rst asserted during CALC byte 2 -> no rsp_valid afterwards, prio 0, next req1-only request granted normally.

Source files
------------

// File: rtl/adder_byte_sequencer.sv
// Two-requester 32-bit add/sub unit built around a single 8-bit ripple slice.
// Each operation takes four byte passes.
module adder_byte_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_cout,
    output logic        rsp_ovf,
    output logic        rsp_id,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic        prio;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] res_q;
    logic        id_q;
    logic        carry;
    logic [1:0]  idx;

    logic [7:0]  sa;
    logic [7:0]  sb;
    logic [7:0]  sum8;
    logic        cout8;
    logic        cy;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE) begin
            req0_ready = req0_valid && (!req1_valid || !prio);
            req1_ready = req1_valid && (!req0_valid || prio);
        end
    end

    assign busy = (state != IDLE);

    // The only adder in the design: an explicit 8-bit ripple chain.
    always_comb begin
        sa = a_q[{idx, 3'b000} +: 8];
        sb = b_q[{idx, 3'b000} +: 8];
        sum8 = 8'h00;
        cy = carry;
        for (int i = 0; i < 8; i++) begin
            sum8[i] = sa[i] ^ sb[i] ^ cy;
            cy = (sa[i] & sb[i]) | (cy & (sa[i] ^ sb[i]));
        end
        cout8 = cy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            id_q       <= 1'b0;
            carry      <= 1'b0;
            idx        <= 2'd0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        // b is stored pre-inverted for subtract; carry-in supplies the +1
                        if (req1_ready) begin
                            a_q   <= req1_a;
                            b_q   <= req1_sub ? ~req1_b : req1_b;
                            carry <= req1_sub;
                        end else begin
                            a_q   <= req0_a;
                            b_q   <= req0_sub ? ~req0_b : req0_b;
                            carry <= req0_sub;
                        end
                        id_q  <= req1_ready;
                        prio  <= !req1_ready;
                        idx   <= 2'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    res_q[{idx, 3'b000} +: 8] <= sum8;
                    carry <= cout8;
                    idx   <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state      <= DONE;
                        rsp_valid  <= 1'b1;
                        rsp_result <= {sum8, res_q[23:0]};
                        rsp_cout   <= cout8;
                        rsp_ovf    <= (a_q[31] == b_q[31]) && (sum8[7] != a_q[31]);
                        rsp_id     <= id_q;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_byte_sequencer.sv
// Randomised bench for adder_byte_sequencer against a transaction-level model.
// Model tracks arbitration, latency and arithmetic results.
module tb_adder_byte_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout, rsp_ovf, rsp_id;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: 0 idle, 1 computing, 2 holding a response
    int          m_state = 0;
    int          m_cnt   = 0;
    bit          m_prio  = 1'b0;
    int          m_acc   = 0;
    logic [31:0] m_res;
    bit          m_cout, m_ovf, m_id;
    bit          grants[$];

    adder_byte_sequencer dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .rsp_ovf(rsp_ovf), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_op(input logic [31:0] a, input logic [31:0] b,
                             input bit sub);
        longint sa, sb, full;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        full   = sub ? sa - sb : sa + sb;
        m_res  = sub ? a - b : a + b;
        m_cout = sub ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
        m_ovf  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    endtask

    // Inputs for the coming edge are already driven; check then advance.
    task automatic step();
        bit e0, e1;
        #1;
        e0 = (m_state == 0) && req0_valid && (!req1_valid || !m_prio);
        e1 = (m_state == 0) && req1_valid && (!req0_valid || m_prio);
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        chk("busy", busy, m_state != 0);
        chk("rsp_valid", rsp_valid, m_state == 2);
        if (m_state == 2) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_cout", rsp_cout, m_cout);
            chk("rsp_ovf", rsp_ovf, m_ovf);
            chk("rsp_id", rsp_id, m_id);
        end
        if (rst) begin
            m_state = 0;
            m_prio  = 1'b0;
        end else if (m_state == 0) begin
            if (e0 || e1) begin
                m_id = e1;
                if (e1) expect_op(req1_a, req1_b, req1_sub);
                else    expect_op(req0_a, req0_b, req0_sub);
                grants.push_back(e1);
                m_prio  = !e1;
                m_state = 1;
                m_cnt   = 0;
                m_acc++;
            end
        end else if (m_state == 1) begin
            m_cnt++;
            if (m_cnt == 4) m_state = 2;
        end else if (rsp_ready) begin
            m_state = 0;
        end
        @(negedge clk);
    endtask

    task automatic op(input bit id, input logic [31:0] a, input logic [31:0] b,
                      input bit sub);
        int acc0, n;
        acc0 = m_acc;
        n = 0;
        req0_valid = !id;
        req1_valid = id;
        if (id) begin req1_a = a; req1_b = b; req1_sub = sub; end
        else    begin req0_a = a; req0_b = b; req0_sub = sub; end
        while (m_acc == acc0 && n < 20) begin
            step();
            n++;
        end
        if (m_acc == acc0) chk("accept_timeout", 32'd0, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req0_sub = $urandom_range(0, 1);
        req1_a = $urandom; req1_b = $urandom; req1_sub = $urandom_range(0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_state != 0 && n < 40) begin
            step();
            n++;
        end
        if (m_state != 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] edge_vals [4];
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h7FFF_FFFF;
        edge_vals[3] = 32'h8000_0000;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        op(0, 32'h0000_00FF, 32'h0000_0001, 0);  drain();
        op(1, 32'h0000_0005, 32'h0000_0007, 1);  drain();
        op(1, 32'h0000_0007, 32'h0000_0005, 1);  drain();
        op(0, 32'h7FFF_FFFF, 32'h0000_0001, 0);  drain();
        op(0, 32'hFFFF_FFFF, 32'h0000_0001, 0);  drain();
        op(1, 32'h8000_0000, 32'h0000_0001, 1);  drain();

        // response back-pressure in DONE
        rsp_ready = 1'b0;
        op(0, 32'h1234_5678, 32'h0FED_CBA9, 0);
        for (int i = 0; i < 12 && m_state != 2; i++) step();
        repeat (3) step();
        rsp_ready = 1'b1;
        step();
        chk("bp_idle", busy, 0);

        // fair alternation with both requesters pending from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        grants.delete();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            req0_a = $urandom; req0_b = $urandom; req0_sub = $urandom_range(0, 1);
            req1_a = $urandom; req1_b = $urandom; req1_sub = $urandom_range(0, 1);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        chk("grant_count", (grants.size() >= 4), 1);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("grant_order", grants[i], i % 2);

        // reset while byte 2 is in progress
        op(0, 32'hDEAD_BEEF, 32'h0101_0101, 0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        op(1, 32'h0000_0010, 32'h0000_0003, 1);
        chk("post_rst_id", m_id, 1);
        drain();

        for (int i = 0; i < 600; i++) begin
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            req0_a = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            req0_b = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            req1_a = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            req1_b = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            req0_sub = $urandom_range(0, 1);
            req1_sub = $urandom_range(0, 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
